// File: rtl/sw_input_conditioner.sv
// Switch/button front end: two-flop synchronizer, per-bit debounce FSM,
// and registered rise/fall strobes, toggle register and any-change flag.
//
// state | meaning
// IDLE  | synchronized pin agrees with sw_stable; counter held at 0
// COUNT | synchronized pin disagrees; counting consecutive disagreeing edges
module sw_input_conditioner #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 1000000,
  localparam int CNT_W  = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic [WIDTH-1:0] sw_toggle,
  output logic             any_change
);

  typedef enum logic {IDLE, COUNT} state_t;

  // Counter value on the edge that precedes acceptance.
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CNT_MAX - 1);

  logic [WIDTH-1:0] sync1, sync2;
  state_t           state     [WIDTH];
  state_t           state_nxt [WIDTH];
  logic [CNT_W-1:0] cnt       [WIDTH];
  logic [CNT_W-1:0] cnt_nxt   [WIDTH];
  logic [WIDTH-1:0] stable_nxt, rise_nxt, fall_nxt;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      stable_nxt[i] = sw_stable[i];
      rise_nxt[i]   = 1'b0;
      fall_nxt[i]   = 1'b0;
      unique case (state[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (sync2[i] != sw_stable[i]) begin
            // The edge that first sees disagreement is counting edge one.
            if (TERM == '0) begin
              stable_nxt[i] = sync2[i];
              rise_nxt[i]   = sync2[i];
              fall_nxt[i]   = ~sync2[i];
            end else begin
              state_nxt[i] = COUNT;
              cnt_nxt[i]   = CNT_W'(1);
            end
          end
        end
        COUNT: begin
          if (sync2[i] == sw_stable[i]) begin
            state_nxt[i] = IDLE;
            cnt_nxt[i]   = '0;
          end else if (cnt[i] == TERM) begin
            state_nxt[i]  = IDLE;
            cnt_nxt[i]    = '0;
            stable_nxt[i] = sync2[i];
            rise_nxt[i]   = sync2[i];
            fall_nxt[i]   = ~sync2[i];
          end else begin
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          state_nxt[i] = IDLE;
          cnt_nxt[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_toggle  <= '0;
      any_change <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      sync1      <= SW;
      sync2      <= sync1;
      sw_stable  <= stable_nxt;
      sw_rise    <= rise_nxt;
      sw_fall    <= fall_nxt;
      sw_toggle  <= sw_toggle ^ rise_nxt;
      any_change <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_input_conditioner.sv
// Bench for sw_input_conditioner (CNT_MAX=4): hold-length scoreboard checked
// every cycle, plus a table of switch patterns and hand-written reset cases.
module tb_sw_input_conditioner;
  localparam int W  = 2;
  localparam int CM = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] SW = '0;
  logic [W-1:0] sw_stable, sw_rise, sw_fall, sw_toggle;
  logic         any_change;

  sw_input_conditioner #(.WIDTH(W), .CNT_MAX(CM)) dut (
    .clk(clk), .rst_n(rst_n), .SW(SW),
    .sw_stable(sw_stable), .sw_rise(sw_rise), .sw_fall(sw_fall),
    .sw_toggle(sw_toggle), .any_change(any_change)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int   edge_n;
    int   bit_n;
    logic val;
  } exp_t;
  exp_t q[$];

  logic [W-1:0] last_s = '0, mstable = '0, exp_stable = '0, exp_toggle = '0;
  logic [W-1:0] er = '0, ef = '0;
  int           run_len [W];
  logic         armed = 1'b0;

  // Predict acceptances from how long each pin has held its value as
  // sampled by the first synchronizer flop.
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      armed      = 1'b1;
      last_s     = '0;
      mstable    = '0;
      exp_stable = '0;
      exp_toggle = '0;
      for (int i = 0; i < W; i++) run_len[i] = 0;
      q.delete();
    end else begin
      for (int i = 0; i < W; i++) begin
        if (SW[i] != last_s[i]) run_len[i] = 1;
        else if (run_len[i] < CM) run_len[i]++;
        last_s[i] = SW[i];
        if (run_len[i] == CM && SW[i] != mstable[i]) begin
          q.push_back('{cyc + 2, i, SW[i]});
          mstable[i] = SW[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      er = '0;
      ef = '0;
      while (q.size() > 0 && q[0].edge_n <= cyc) begin
        if (q[0].edge_n == cyc) begin
          if (q[0].val) er[q[0].bit_n] = 1'b1;
          else          ef[q[0].bit_n] = 1'b1;
        end
        void'(q.pop_front());
      end
      exp_stable = (exp_stable | er) & ~ef;
      exp_toggle = exp_toggle ^ er;
      total++;
      if ({sw_stable, sw_rise, sw_fall, sw_toggle, any_change} !==
          {exp_stable, er, ef, exp_toggle, |(er | ef)}) begin
        bad++;
        $display("FAIL sb_cycle%0d: got stable=%b rise=%b fall=%b toggle=%b any=%b want stable=%b rise=%b fall=%b toggle=%b any=%b",
                 cyc, sw_stable, sw_rise, sw_fall, sw_toggle, any_change,
                 exp_stable, er, ef, exp_toggle, |(er | ef));
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  typedef struct {
    logic [W-1:0] sw;
    int           hold;
    logic [W-1:0] exp_stable;
    logic [W-1:0] exp_toggle;
  } vec_t;
  vec_t tbl [13];

  initial begin
    tbl[0]  = '{2'b01, 8,  2'b01, 2'b01};  // clean press
    tbl[1]  = '{2'b00, 2,  2'b01, 2'b01};  // release glitch
    tbl[2]  = '{2'b01, 8,  2'b01, 2'b01};
    tbl[3]  = '{2'b00, 8,  2'b00, 2'b01};  // release keeps toggle
    tbl[4]  = '{2'b01, 3,  2'b00, 2'b01};  // one short of CNT_MAX
    tbl[5]  = '{2'b00, 3,  2'b00, 2'b01};
    tbl[6]  = '{2'b01, 8,  2'b01, 2'b00};  // second press flips toggle
    tbl[7]  = '{2'b11, 8,  2'b11, 2'b10};
    tbl[8]  = '{2'b00, 8,  2'b00, 2'b10};
    tbl[9]  = '{2'b11, 8,  2'b11, 2'b01};  // simultaneous rises
    tbl[10] = '{2'b10, 4,  2'b11, 2'b01};  // exactly CNT_MAX, not yet visible
    tbl[11] = '{2'b11, 8,  2'b11, 2'b00};
    tbl[12] = '{2'b00, 10, 2'b00, 2'b00};

    // Reset with pins high, then release.
    SW = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {sw_stable, sw_rise, sw_fall, sw_toggle}, 8'h00);
    chk("rst_any", any_change, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rel_pre_stable", sw_stable, 2'b00);
    @(negedge clk);
    chk("rel_stable", sw_stable, 2'b11);
    chk("rel_rise", sw_rise, 2'b11);
    chk("rel_any", any_change, 1'b1);
    chk("rel_toggle", sw_toggle, 2'b11);
    @(negedge clk);
    chk("rel_rise_end", sw_rise, 2'b00);
    chk("rel_any_end", any_change, 1'b0);

    SW = 2'b00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int k = 0; k < 13; k++) begin
      SW = tbl[k].sw;
      repeat (tbl[k].hold) @(negedge clk);
      chk($sformatf("tbl%0d_stable", k), sw_stable, tbl[k].exp_stable);
      chk($sformatf("tbl%0d_toggle", k), sw_toggle, tbl[k].exp_toggle);
    end

    // Reset lands on the third counting edge of a SW[1] press.
    SW = 2'b10;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_stable", sw_stable, 2'b00);
    chk("midrst_rise", sw_rise, 2'b00);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_pre_stable", sw_stable, 2'b00);
    @(negedge clk);
    chk("midrst_stable_after", sw_stable, 2'b10);
    chk("midrst_rise_after", sw_rise, 2'b10);
    repeat (3) @(negedge clk);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
